total_alu_mdu: RTL and testbench

- Parametrised successor to the datapath ALU: a combinational single-cycle ALU plus a sequential multiply/divide unit (MDU) holding HI/LO registers.
- Adds DIVU, SRL, SRA, NOR and SLTU, plus an explicit busy/done handshake and a divide-by-zero flag.
- Sits in the EX stage, driven by the 6-bit funct code on Signal. The result is read back with MFHI/MFLO.

---
 rtl/total_alu_mdu_pkg.sv | 25 ++
 rtl/total_alu_mdu_seq_muldiv.sv | 108 ++++++++++
 rtl/total_alu_mdu.sv | 57 +++++
 tb/tb_total_alu_mdu.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/total_alu_mdu_pkg.sv
// Funct codes and MDU state encoding shared by the ALU top and the multiply/divide unit.
package alu_pkg;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/total_alu_mdu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per clock, WIDTH clocks per op.
// HI/LO are written on the last iteration edge; done pulses for the cycle that follows.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       signal_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state_q;
  logic             armed_q, is_div_q, busy_q, done_q, div0_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, sh_q, b_q, hi_q, lo_q;
  logic [WIDTH-1:0] acc_d, sh_d;

  logic             mdu_req;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;

  assign mdu_req = (signal_i == F_MULTU) || (signal_i == F_DIVU);

  // acc/sh act as {HI,LO} for multiply and as {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {acc_q, sh_q[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, b_q};
    ge      = ~diff[WIDTH+1];
    acc_d   = mul_sum[WIDTH:1];
    sh_d    = {mul_sum[0], sh_q[WIDTH-1:1]};
    if (is_div_q) begin
      acc_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], ge};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b1;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (!mdu_req) armed_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (mdu_req && armed_q) begin
            armed_q  <= 1'b0;
            state_q  <= S_RUN;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= a_i;
            b_q      <= b_i;
            is_div_q <= (signal_i == F_DIVU);
            div0_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            hi_q    <= acc_d;
            lo_q    <= sh_d;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            div0_q  <= is_div_q && (b_q == '0);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign div0_o = div0_q;

endmodule

// File: rtl/total_alu_mdu.sv
// EX-stage ALU: single-cycle combinational ops plus MFHI/MFLO reads of the sequential MDU.
module total_alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  logic [WIDTH-1:0] hi, lo;
  logic [SHW-1:0]   shamt;

  assign shamt = dataB[SHW-1:0];

  seq_muldiv #(.WIDTH(WIDTH)) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .signal_i (Signal),
    .a_i      (dataA),
    .b_i      (dataB),
    .hi_o     (hi),
    .lo_o     (lo),
    .busy_o   (busy),
    .done_o   (done),
    .div0_o   (div0)
  );

  // MULTU/DIVU and unknown codes fall into default and read as zero.
  always_comb begin
    Output = '0;
    case (Signal)
      F_AND:  Output = dataA & dataB;
      F_OR:   Output = dataA | dataB;
      F_NOR:  Output = ~(dataA | dataB);
      F_ADD:  Output = dataA + dataB;
      F_SUB:  Output = dataA - dataB;
      F_SLT:  Output = {{(WIDTH-1){1'b0}}, $signed(dataA) < $signed(dataB)};
      F_SLTU: Output = {{(WIDTH-1){1'b0}}, dataA < dataB};
      F_SLL:  Output = dataA << shamt;
      F_SRL:  Output = dataA >> shamt;
      F_SRA:  Output = $unsigned($signed(dataA) >>> shamt);
      F_MFHI: Output = hi;
      F_MFLO: Output = lo;
      default: Output = '0;
    endcase
  end

endmodule

// File: tb/tb_total_alu_mdu.sv
// Randomised and directed checks of total_alu_mdu (WIDTH=32 and WIDTH=8) against an arithmetic model.
module tb_total_alu_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB, Output;
  logic [5:0]  Signal;
  logic        busy, done, div0;

  logic [7:0]  a8, b8, out8;
  logic [5:0]  sig8;
  logic        busy8, done8, div08;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;

  total_alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .Output(Output), .busy(busy), .done(done), .div0(div0)
  );

  total_alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .dataA(a8), .dataB(b8), .Signal(sig8),
    .Output(out8), .busy(busy8), .done(done8), .div0(div08)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = b % 32;
    fill = ~(32'hffff_ffff >> sh);
    case (s)
      F_AND:  return a & b;
      F_OR:   return a | b;
      F_NOR:  return ~(a | b);
      F_ADD:  return a + b;
      F_SUB:  return a - b;
      F_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      F_SLTU: return (a < b) ? 32'd1 : 32'd0;
      F_SLL:  return a << sh;
      F_SRL:  return a >> sh;
      F_SRA:  return (a >> sh) | (a[31] ? fill : 32'd0);
      F_MFHI: return hi_m;
      F_MFLO: return lo_m;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_mdu(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (s == F_MULTU) begin
      p = 64'(a) * 64'(b);
      hi_m = p[63:32];
      lo_m = p[31:0];
    end else if (b == 0) begin
      hi_m = a;
      lo_m = 32'hffff_ffff;
    end else begin
      hi_m = a % b;
      lo_m = a / b;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Signal = F_ADD; dataA = 0; dataB = 0;
    sig8 = F_ADD; a8 = 0; b8 = 0;
    step(); step();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy/done/div0 %b%b%b expected 000", busy, done, div0);
    end
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0 || div08 !== 1'b0) begin
      errors++; $display("FAIL reset_flags8: busy/done/div0 %b%b%b expected 000", busy8, done8, div08);
    end
    Signal = F_MFHI; settle();
    checks++; if (Output !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", Output); end
    Signal = F_MFLO; settle();
    checks++; if (Output !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", Output); end
    reset = 1'b0; Signal = F_ADD;
    hi_m = 0; lo_m = 0;
    step();
  endtask

  task automatic test_comb_directed();
    logic [5:0]  s  [6] = '{F_ADD, F_SUB, F_SLT, F_SLTU, F_SRA, F_NOR};
    logic [31:0] a  [6] = '{32'h7fffffff, 32'h0, 32'hffffffff, 32'hffffffff, 32'h80000000, 32'h0};
    logic [31:0] b  [6] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h4, 32'h0};
    logic [31:0] ex [6] = '{32'h80000000, 32'hffffffff, 32'h1, 32'h0, 32'hf8000000, 32'hffffffff};
    for (int i = 0; i < 6; i++) begin
      Signal = s[i]; dataA = a[i]; dataB = b[i]; settle();
      checks++; if (Output !== ex[i]) begin
        errors++; $display("FAIL comb_directed[%0d] code %0d: got %h expected %h", i, s[i], Output, ex[i]);
      end
    end
    Signal = F_ADD;
  endtask

  task automatic test_comb_random();
    logic [5:0] s;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: s = 6'($urandom_range(0, 63));
        1: s = F_SRA;
        2: s = (i % 2) ? F_SLT : F_SLTU;
        default: s = (i % 2) ? F_MFHI : F_MFLO;
      endcase
      if (s == F_MULTU || s == F_DIVU) s = F_NOR;
      dataA = $urandom(); dataB = $urandom();
      if (i % 5 == 0) dataA[31] = 1'b1;
      Signal = s; settle();
      checks++; if (Output !== ref_alu(s, dataA, dataB)) begin
        errors++; $display("FAIL comb_random code %0d a %h b %h: got %h expected %h",
                           s, dataA, dataB, Output, ref_alu(s, dataA, dataB));
      end
      if (i % 7 == 0) step();
    end
    Signal = F_ADD;
    step();
  endtask

  task automatic run_mdu(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic exp_div0;
    exp_div0 = (s == F_DIVU) && (b == 0);
    Signal = s; dataA = a; dataB = b;
    step();
    checks++; if (busy !== 1'b1 || div0 !== 1'b0) begin
      errors++; $display("FAIL mdu_launch: busy %b div0 %b expected busy 1 div0 0", busy, div0);
    end
    Signal = F_ADD; dataA = $urandom(); dataB = $urandom();
    n = 0;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (done !== 1'b1 || n != 32) begin
      errors++; $display("FAIL mdu_latency: done after %0d cycles (done=%b) expected 32", n, done);
    end
    model_mdu(s, a, b);
    checks++; if (div0 !== exp_div0 || busy !== 1'b0) begin
      errors++; $display("FAIL mdu_flags: div0 %b busy %b expected div0 %b busy 0", div0, busy, exp_div0);
    end
    Signal = F_MFHI; settle();
    checks++; if (Output !== hi_m) begin
      errors++; $display("FAIL mdu_hi code %0d a %h b %h: got %h expected %h", s, a, b, Output, hi_m);
    end
    Signal = F_MFLO; settle();
    checks++; if (Output !== lo_m) begin
      errors++; $display("FAIL mdu_lo code %0d a %h b %h: got %h expected %h", s, a, b, Output, lo_m);
    end
    Signal = F_ADD;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done %b expected 0", done); end
  endtask

  task automatic test_multu_held();
    int busy_cnt = 0, done_cnt = 0;
    Signal = F_MULTU; dataA = 32'hffffffff; dataB = 32'hffffffff;
    for (int i = 0; i < 36; i++) begin
      step();
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (busy_cnt != 32) begin errors++; $display("FAIL held_busy_cycles: got %0d expected 32", busy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL held_done_pulses: got %0d expected 1", done_cnt); end
    model_mdu(F_MULTU, 32'hffffffff, 32'hffffffff);
    Signal = F_MFHI; settle();
    checks++; if (Output !== 32'hfffffffe) begin errors++; $display("FAIL held_hi: got %h expected fffffffe", Output); end
    Signal = F_MFLO; settle();
    checks++; if (Output !== 32'h00000001) begin errors++; $display("FAIL held_lo: got %h expected 00000001", Output); end
    Signal = F_ADD;
    step();
  endtask

  task automatic test_during_run();
    int n;
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    Signal = F_MULTU; dataA = a; dataB = b;
    step();
    Signal = F_ADD;
    repeat (5) step();
    Signal = F_MFLO; settle();
    checks++; if (Output !== 32'd14 || busy !== 1'b1) begin
      errors++; $display("FAIL run_old_lo: got %h busy %b expected 0000000e busy 1", Output, busy);
    end
    Signal = F_ADD; dataA = $urandom(); dataB = $urandom(); settle();
    checks++; if (Output !== dataA + dataB || busy !== 1'b1) begin
      errors++; $display("FAIL run_add: got %h busy %b expected %h busy 1", Output, busy, dataA + dataB);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done: done %b expected 1", done); end
    model_mdu(F_MULTU, a, b);
    Signal = F_MFHI; settle();
    checks++; if (Output !== hi_m) begin errors++; $display("FAIL run_hi: got %h expected %h", Output, hi_m); end
    Signal = F_ADD;
    step();
  endtask

  task automatic test_reset_mid();
    bit saw_done = 0;
    Signal = F_MULTU; dataA = $urandom() | 32'h1; dataB = $urandom() | 32'h1;
    step();
    Signal = F_ADD;
    repeat (9) step();
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_flags: busy %b done %b expected 0 0", busy, done);
    end
    reset = 1'b0;
    hi_m = 0; lo_m = 0;
    repeat (40) begin step(); if (done === 1'b1) saw_done = 1; end
    checks++; if (saw_done) begin errors++; $display("FAIL reset_mid_done: done pulse 1 expected none"); end
    Signal = F_MFHI; settle();
    checks++; if (Output !== 32'h0) begin errors++; $display("FAIL reset_mid_hi: got %h expected 0", Output); end
    Signal = F_MFLO; settle();
    checks++; if (Output !== 32'h0) begin errors++; $display("FAIL reset_mid_lo: got %h expected 0", Output); end
    Signal = F_ADD;
    step();
  endtask

  task automatic test_width8();
    logic [5:0] s  [2] = '{F_MULTU, F_DIVU};
    logic [7:0] a  [2] = '{8'hff, 8'd200};
    logic [7:0] b  [2] = '{8'hff, 8'd3};
    logic [7:0] eh [2] = '{8'hfe, 8'd2};
    logic [7:0] el [2] = '{8'h01, 8'd66};
    int n;
    for (int i = 0; i < 2; i++) begin
      sig8 = s[i]; a8 = a[i]; b8 = b[i];
      step();
      sig8 = F_ADD;
      n = 0;
      while (done8 !== 1'b1 && n < 20) begin step(); n++; end
      checks++; if (done8 !== 1'b1 || n != 8) begin
        errors++; $display("FAIL w8_latency[%0d]: done after %0d cycles expected 8", i, n);
      end
      sig8 = F_MFHI; settle();
      checks++; if (out8 !== eh[i]) begin errors++; $display("FAIL w8_hi[%0d]: got %h expected %h", i, out8, eh[i]); end
      sig8 = F_MFLO; settle();
      checks++; if (out8 !== el[i]) begin errors++; $display("FAIL w8_lo[%0d]: got %h expected %h", i, out8, el[i]); end
      sig8 = F_ADD;
      step();
    end
    sig8 = F_SRA; a8 = 8'h80; b8 = 8'h0b; settle();
    checks++; if (out8 !== 8'hf0) begin errors++; $display("FAIL w8_sra: got %h expected f0", out8); end
    sig8 = F_ADD;
  endtask

  task automatic test_random_mdu();
    logic [31:0] b;
    for (int i = 0; i < 6; i++) begin
      b = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      run_mdu((i % 2) ? F_MULTU : F_DIVU, $urandom(), b);
    end
  endtask

  initial begin
    test_reset();
    test_comb_directed();
    test_multu_held();
    run_mdu(F_DIVU, 32'd100, 32'd7);
    test_during_run();
    run_mdu(F_DIVU, 32'd5, 32'd0);
    run_mdu(F_MULTU, 32'd3, 32'd9);
    test_reset_mid();
    test_width8();
    test_random_mdu();
    test_comb_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
